// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register for the 5-stage ARM pipeline.
//               Captures decoded control and operand fields, inserts bubbles
//               on hazards or failed condition checks, clears on branch
//               flush, holds on freeze, and counts inserted bubbles
//               (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,              // asynchronous, active-low
  input  logic              flush,
  input  logic              freeze,
  input  logic              hazard,
  input  logic              cond_pass,
  input  logic              valid_in,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic [3:0]        EXE_CMD_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              imm_in,
  input  logic [11:0]       Shift_operand_in,
  input  logic [23:0]       Signed_imm_24_in,
  input  logic [3:0]        Dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        SR_in,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic              B,
  output logic              S,
  output logic [3:0]        EXE_CMD,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] Val_Rn,
  output logic [DATA_W-1:0] Val_Rm,
  output logic              imm,
  output logic [11:0]       Shift_operand,
  output logic [23:0]       Signed_imm_24,
  output logic [3:0]        Dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [3:0]        SR,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_count
);

  // A real instruction whose bubble is inserted because of a hazard or a
  // failed condition; an empty ID slot is not counted as a bubble.
  logic bubble_event;
  // The ID slot carries a real instruction that proceeds into EX.
  logic load_ok;

  assign bubble_event = valid_in & (hazard | ~cond_pass);
  assign load_ok      = valid_in & ~hazard & cond_pass;

  // Control fields and valid: cleared on flush, held on freeze, zeroed when
  // the slot does not carry an instruction that proceeds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_EN     <= 1'b0;
      MEM_R_EN  <= 1'b0;
      MEM_W_EN  <= 1'b0;
      B         <= 1'b0;
      S         <= 1'b0;
      EXE_CMD   <= 4'b0000;
      valid_out <= 1'b0;
    end else if (flush) begin
      WB_EN     <= 1'b0;
      MEM_R_EN  <= 1'b0;
      MEM_W_EN  <= 1'b0;
      B         <= 1'b0;
      S         <= 1'b0;
      EXE_CMD   <= 4'b0000;
      valid_out <= 1'b0;
    end else if (!freeze) begin
      if (load_ok) begin
        WB_EN     <= WB_EN_in;
        MEM_R_EN  <= MEM_R_EN_in;
        MEM_W_EN  <= MEM_W_EN_in;
        B         <= B_in;
        S         <= S_in;
        EXE_CMD   <= EXE_CMD_in;
        valid_out <= 1'b1;
      end else begin
        WB_EN     <= 1'b0;
        MEM_R_EN  <= 1'b0;
        MEM_W_EN  <= 1'b0;
        B         <= 1'b0;
        S         <= 1'b0;
        EXE_CMD   <= 4'b0000;
        valid_out <= 1'b0;
      end
    end
  end

  // Operand, immediate and index fields: cleared on flush, held on freeze,
  // otherwise always captured so bubbles carry deterministic data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC            <= '0;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      Shift_operand <= '0;
      Signed_imm_24 <= '0;
      Dest          <= '0;
      src1          <= '0;
      src2          <= '0;
      SR            <= '0;
    end else if (flush) begin
      PC            <= '0;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      Shift_operand <= '0;
      Signed_imm_24 <= '0;
      Dest          <= '0;
      src1          <= '0;
      src2          <= '0;
      SR            <= '0;
    end else if (!freeze) begin
      PC            <= PC_in;
      Val_Rn        <= Val_Rn_in;
      Val_Rm        <= Val_Rm_in;
      imm           <= imm_in;
      Shift_operand <= Shift_operand_in;
      Signed_imm_24 <= Signed_imm_24_in;
      Dest          <= Dest_in;
      src1          <= src1_in;
      src2          <= src2_in;
      SR            <= SR_in;
    end
  end

  // Saturating bubble counter: untouched by flush and freeze, sticks at
  // all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_count <= '0;
    end else if (!flush && !freeze && bubble_event &&
                 (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Self-checking bench for id_ex_stage_reg: table vectors,
//               hand-written multi-cycle sequences and a randomized run
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        flush, freeze, hazard, cond_pass, valid_in;
    logic        wb, mr, mw, b, s;
    logic [3:0]  exe;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest, src1, src2, sr;
  } in_t;

  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  exe;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest, src1, src2, sr;
    logic        valid;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic        clk, rst;
  logic        flush, freeze, hazard, cond_pass, valid_in;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in;
  logic [3:0]  EXE_CMD_in;
  logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic        imm_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_imm_24_in;
  logic [3:0]  Dest_in, src1_in, src2_in, SR_in;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S;
  logic [3:0]  EXE_CMD;
  logic [31:0] PC, Val_Rn, Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest, src1, src2, SR;
  logic        valid_out;
  logic [15:0] bubble_count;

  int checks   = 0;
  int failures = 0;

  id_ex_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard(hazard),
    .cond_pass(cond_pass), .valid_in(valid_in),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .B_in(B_in), .S_in(S_in), .EXE_CMD_in(EXE_CMD_in),
    .PC_in(PC_in), .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in),
    .imm_in(imm_in), .Shift_operand_in(Shift_operand_in),
    .Signed_imm_24_in(Signed_imm_24_in), .Dest_in(Dest_in),
    .src1_in(src1_in), .src2_in(src2_in), .SR_in(SR_in),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
    .EXE_CMD(EXE_CMD), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
    .Dest(Dest), .src1(src1), .src2(src2), .SR(SR),
    .valid_out(valid_out), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apply(input in_t v);
    flush = v.flush; freeze = v.freeze; hazard = v.hazard;
    cond_pass = v.cond_pass; valid_in = v.valid_in;
    WB_EN_in = v.wb; MEM_R_EN_in = v.mr; MEM_W_EN_in = v.mw;
    B_in = v.b; S_in = v.s; EXE_CMD_in = v.exe;
    PC_in = v.pc; Val_Rn_in = v.rn; Val_Rm_in = v.rm; imm_in = v.imm;
    Shift_operand_in = v.shop; Signed_imm_24_in = v.simm;
    Dest_in = v.dest; src1_in = v.src1; src2_in = v.src2; SR_in = v.sr;
  endtask

  function automatic out_t actual();
    out_t a;
    a.wb = WB_EN; a.mr = MEM_R_EN; a.mw = MEM_W_EN; a.b = B; a.s = S;
    a.exe = EXE_CMD; a.pc = PC; a.rn = Val_Rn; a.rm = Val_Rm; a.imm = imm;
    a.shop = Shift_operand; a.simm = Signed_imm_24; a.dest = Dest;
    a.src1 = src1; a.src2 = src2; a.sr = SR; a.valid = valid_out;
    a.cnt = bubble_count;
    return a;
  endfunction

  task automatic chk(input string nm, input out_t e);
    out_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [15:0] e);
    checks++;
    if (bubble_count !== e) begin
      failures++;
      $display("FAIL %s bubble_count actual=%h required=%h", nm, bubble_count, e);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising.
  task automatic cycle(input in_t v);
    @(negedge clk);
    apply(v);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t rand_in();
    logic [191:0] t;
    in_t r;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r = t[$bits(in_t)-1:0];
    return r;
  endfunction

  // Data fields pass straight through on any non-flush, non-freeze edge.
  function automatic out_t data_of(input in_t i, input logic [15:0] cnt);
    out_t o;
    o = '0;
    o.pc = i.pc; o.rn = i.rn; o.rm = i.rm; o.imm = i.imm; o.shop = i.shop;
    o.simm = i.simm; o.dest = i.dest; o.src1 = i.src1; o.src2 = i.src2;
    o.sr = i.sr; o.cnt = cnt;
    return o;
  endfunction

  // Reference model: what the EX side should see after one edge.
  function automatic out_t model(input in_t i, input out_t p);
    out_t o;
    int   n;
    bit   real_insn, is_bubble;
    n = int'(p.cnt);
    if (i.flush) begin
      o = '0;
      o.cnt = p.cnt;
      return o;
    end
    if (i.freeze) return p;
    real_insn = i.valid_in && !i.hazard && i.cond_pass;
    is_bubble = i.valid_in && (i.hazard || !i.cond_pass);
    if (is_bubble) n = (n + 1 > 65535) ? 65535 : n + 1;
    o = data_of(i, 16'(n));
    if (real_insn) begin
      o.wb = i.wb; o.mr = i.mr; o.mw = i.mw; o.b = i.b; o.s = i.s;
      o.exe = i.exe; o.valid = 1'b1;
    end
    return o;
  endfunction

  vec_t vec[7];
  out_t exp_s;

  initial begin
    in_t  t;
    out_t e;

    // ---------------- vector table ----------------
    t = '0; t.valid_in = 1; t.cond_pass = 1; t.wb = 1; t.exe = 4'd2;
    t.pc = 32'h104; t.rn = 32'h5; t.rm = 32'h7; t.dest = 4'd3;
    t.src1 = 4'd1; t.src2 = 4'd2;
    e = data_of(t, 16'd0); e.wb = 1; e.exe = 4'd2; e.valid = 1;
    vec[0] = '{"add_load", t, e};

    t = '0; t.valid_in = 1; t.cond_pass = 1; t.hazard = 1; t.wb = 1; t.mr = 1;
    t.exe = 4'd2; t.pc = 32'h108; t.rn = 32'h10; t.imm = 1;
    t.shop = 12'h004; t.dest = 4'd4; t.src1 = 4'd3;
    e = data_of(t, 16'd1);
    vec[1] = '{"ldr_hazard_bubble", t, e};

    t.cond_pass = 0;
    e = data_of(t, 16'd2);
    vec[2] = '{"hazard_and_condfail_single", t, e};

    t = '0; t.valid_in = 0; t.cond_pass = 1; t.wb = 1; t.mw = 1;
    t.exe = 4'd9; t.pc = 32'h10c; t.rn = 32'hdead; t.sr = 4'ha;
    e = data_of(t, 16'd2);
    vec[3] = '{"invalid_slot", t, e};

    t = '0; t.valid_in = 1; t.cond_pass = 1; t.s = 1; t.wb = 0;
    t.exe = 4'd4; t.pc = 32'h110; t.rn = 32'h9; t.rm = 32'h9;
    t.src1 = 4'd5; t.src2 = 4'd6; t.sr = 4'h4;
    e = data_of(t, 16'd2); e.s = 1; e.exe = 4'd4; e.valid = 1;
    vec[4] = '{"cmp_s_flag", t, e};

    t = '0; t.valid_in = 1; t.cond_pass = 0; t.wb = 1; t.exe = 4'd3;
    t.pc = 32'h114; t.dest = 4'd7;
    e = data_of(t, 16'd3);
    vec[5] = '{"condfail_bubble", t, e};

    t = '0; t.valid_in = 1; t.cond_pass = 1; t.b = 1; t.exe = 4'd0;
    t.pc = 32'h118; t.simm = 24'hfffffe; t.sr = 4'hf;
    e = data_of(t, 16'd3); e.b = 1; e.valid = 1;
    vec[6] = '{"branch_load", t, e};

    // ---------------- reset without clock edge ----------------
    rst = 1'b0;
    apply(rand_in());
    #2;
    chk("reset_async", '0);

    // Release, then one load edge.
    @(negedge clk);
    rst = 1'b1;
    t = rand_in(); t.flush = 0; t.freeze = 0; t.valid_in = 1;
    t.hazard = 0; t.cond_pass = 1;
    cycle(t);
    checks++;
    if (valid_out !== 1'b1 || bubble_count !== 16'd0) begin
      failures++;
      $display("FAIL post_reset_load valid_out=%b bubble_count=%h required=1/0000",
               valid_out, bubble_count);
    end

    // ---------------- table ----------------
    for (int k = 0; k < 7; k++) begin
      cycle(vec[k].i);
      chk(vec[k].name, vec[k].e);
    end
    exp_s = vec[6].e;

    // ---------------- freeze for three cycles ----------------
    for (int k = 0; k < 3; k++) begin
      t = rand_in(); t.flush = 0; t.freeze = 1;
      cycle(t);
      chk("freeze_hold", exp_s);
    end

    // ---------------- flush overrides freeze ----------------
    t = rand_in(); t.flush = 1; t.freeze = 1;
    cycle(t);
    e = '0; e.cnt = 16'd3;
    chk("flush_over_freeze", e);
    exp_s = e;

    // ---------------- saturation ----------------
    t = '0; t.valid_in = 1; t.hazard = 1; t.cond_pass = 1;
    for (int k = 0; k < 65534 - 3; k++) begin
      cycle(t);
      exp_s = model(t, exp_s);
    end
    chk_cnt("sat_preload", 16'hfffe);
    for (int k = 0; k < 3; k++) begin
      cycle(t);
      exp_s = model(t, exp_s);
      chk_cnt("sat_hold", 16'hffff);
      chk("sat_state", exp_s);
    end

    // ---------------- reset asserted mid-freeze ----------------
    t = vec[0].i; t.freeze = 1;
    cycle(t);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_mid_freeze", '0);
    @(negedge clk);
    rst = 1'b1;
    exp_s = '0;

    // ---------------- randomized run against model ----------------
    for (int k = 0; k < 400; k++) begin
      t = rand_in();
      t.flush     = ($urandom_range(0, 9) == 0);
      t.freeze    = ($urandom_range(0, 5) == 0);
      t.hazard    = ($urandom_range(0, 3) == 0);
      t.cond_pass = ($urandom_range(0, 3) != 0);
      t.valid_in  = ($urandom_range(0, 7) != 0);
      cycle(t);
      exp_s = model(t, exp_s);
      chk("random", exp_s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
